// File: rtl/e_ring_alloc.sv
// Circular next-fit slot allocator: hands out one free entry per cycle, searching
// downward from the last-allocated position, and accepts one release per cycle.
module e_ring_alloc #(
    parameter  int N   = 16,
    parameter  int W   = 4,
    localparam int IDW = $clog2(N),
    localparam int CW  = $clog2(N + 1)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           alloc_req_i,
    output logic           alloc_gnt_o,
    output logic [IDW-1:0] alloc_id_o,
    input  logic           free_vld_i,
    input  logic [IDW-1:0] free_id_i,
    output logic [N-1:0]   busy_o,
    output logic [CW-1:0]  cnt_o,
    output logic           full_o,
    output logic           empty_o,
    output logic           err_o
);

    localparam int             NS    = N / W;
    localparam logic [N-1:0]   ONE_N = N'(1);
    localparam logic [CW-1:0]  ONE_C = CW'(1);
    localparam logic [CW-1:0]  NCNT  = CW'(N);
    localparam logic [IDW:0]   NLIM  = (IDW + 1)'(N);

    logic [N-1:0]       busy_q, busy_d, ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               full_q, full_d, empty_q, empty_d, err_q, err_d;

    logic [N-1:0]       freeVec, maskFree;
    logic               hitM, carryM, carryU, cinM, cinU, segFoundM, segFoundU;
    logic [IDW-1:0]     idM, idU, allocId;
    logic               gnt, freeInRange, freeBusy, freeOk, freeErr;
    logic [N-1:0]       allocOH, freeOH;
    logic [2**IDW-1:0]  busyExt;

    // Two chained passes over W-wide segments, top segment first. The masked pass
    // only sees entries below the pointer and starts at the pointer's segment; the
    // unmasked pass covers the wrap-around and is used only when the first misses.
    always_comb begin
        freeVec   = ~busy_q;
        maskFree  = freeVec & (ptr_q - ONE_N);
        carryM    = 1'b0;
        carryU    = 1'b1;
        hitM      = 1'b0;
        idM       = '0;
        idU       = '0;
        cinM      = 1'b0;
        cinU      = 1'b0;
        segFoundM = 1'b0;
        segFoundU = 1'b0;
        for (int s = NS - 1; s >= 0; s--) begin
            cinM      = carryM | (|ptr_q[s*W +: W]);
            cinU      = carryU;
            segFoundM = 1'b0;
            segFoundU = 1'b0;
            for (int b = W - 1; b >= 0; b--) begin
                if (cinM && !segFoundM && maskFree[s*W + b]) begin
                    segFoundM = 1'b1;
                    idM       = IDW'(s*W + b);
                end
                if (cinU && !segFoundU && freeVec[s*W + b]) begin
                    segFoundU = 1'b1;
                    idU       = IDW'(s*W + b);
                end
            end
            hitM   = hitM | segFoundM;
            carryM = cinM & ~segFoundM;
            carryU = cinU & ~segFoundU;
        end
        allocId = hitM ? idM : idU;
    end

    // Grant and release qualification; out-of-range IDs read as not-busy.
    always_comb begin
        busyExt          = '0;
        busyExt[N-1:0]   = busy_q;
        gnt              = alloc_req_i & ~full_q & rst_n_i;
        freeInRange      = ({1'b0, free_id_i} < NLIM);
        freeBusy         = freeInRange & busyExt[free_id_i];
        freeOk           = free_vld_i & freeBusy;
        freeErr          = free_vld_i & ~freeBusy;
        allocOH          = ONE_N << allocId;
        freeOH           = ONE_N << free_id_i;
    end

    always_comb begin
        busy_d = (busy_q | (gnt ? allocOH : '0)) & ~(freeOk ? freeOH : '0);
        ptr_d  = gnt ? allocOH : ptr_q;
        cnt_d  = cnt_q;
        case ({gnt, freeOk})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == NCNT);
        empty_d = (cnt_d == '0);
        err_d   = err_q | freeErr;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q  <= '0;
            ptr_q   <= ONE_N;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign alloc_gnt_o = gnt;
    assign alloc_id_o  = allocId;
    assign busy_o      = busy_q;
    assign cnt_o       = cnt_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_e_ring_alloc.sv
// Bench for e_ring_alloc: two instances (N=16/W=4 and N=12/W=3) driven by directed
// and random cycles, each checked against a list-level next-fit reference model.
module tb_e_ring_alloc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn16 = 1'b0, req16 = 1'b0, fv16 = 1'b0;
    logic [3:0]  fid16 = '0;
    logic        gnt16, full16, empty16, err16;
    logic [3:0]  id16;
    logic [15:0] busy16;
    logic [4:0]  cnt16;

    logic        rstn12 = 1'b0, req12 = 1'b0, fv12 = 1'b0;
    logic [3:0]  fid12 = '0;
    logic        gnt12, full12, empty12, err12;
    logic [3:0]  id12;
    logic [11:0] busy12;
    logic [3:0]  cnt12;

    e_ring_alloc #(.N(16), .W(4)) dut16 (
        .clk_i(clk), .rst_n_i(rstn16), .alloc_req_i(req16), .alloc_gnt_o(gnt16),
        .alloc_id_o(id16), .free_vld_i(fv16), .free_id_i(fid16), .busy_o(busy16),
        .cnt_o(cnt16), .full_o(full16), .empty_o(empty16), .err_o(err16)
    );

    e_ring_alloc #(.N(12), .W(3)) dut12 (
        .clk_i(clk), .rst_n_i(rstn12), .alloc_req_i(req12), .alloc_gnt_o(gnt12),
        .alloc_id_o(id12), .free_vld_i(fv12), .free_id_i(fid12), .busy_o(busy12),
        .cnt_o(cnt12), .full_o(full12), .empty_o(empty12), .err_o(err12)
    );

    int        nAsserts = 0;
    int        nFail    = 0;
    int        mN[2]    = '{16, 12};
    bit [15:0] mBusy[2];
    int        mPtr[2];
    int        mCnt[2];
    bit        mErr[2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next-fit rule: p-1 down to 0, then N-1 down to p.
    function automatic int mSearch(input int k);
        for (int i = mPtr[k] - 1; i >= 0; i--)
            if (!mBusy[k][i]) return i;
        for (int i = mN[k] - 1; i >= mPtr[k]; i--)
            if (!mBusy[k][i]) return i;
        return -1;
    endfunction

    function automatic int pickBusy(input int k);
        int start = int'($urandom_range(0, mN[k] - 1));
        for (int j = 0; j < mN[k]; j++)
            if (mBusy[k][(start + j) % mN[k]]) return (start + j) % mN[k];
        return start;
    endfunction

    // One clock cycle on instance k: drive, check the combinational grant, clock,
    // advance the model, check the registered state.
    task automatic applyStimulus(input int k, input bit rq, input bit fv, input int fid,
                                 input bit rn, output int gotId);
        int   n, expId;
        bit   expGnt, fOk;
        logic ogl;
        logic [3:0] oid;
        n = mN[k];
        if (k == 0) begin
            rstn16 = rn; req16 = rq; fv16 = fv; fid16 = 4'(fid);
        end else begin
            rstn12 = rn; req12 = rq; fv12 = fv; fid12 = 4'(fid);
        end
        #1;
        expGnt = rn && rq && (mCnt[k] < n);
        expId  = mSearch(k);
        ogl    = (k == 0) ? gnt16 : gnt12;
        oid    = (k == 0) ? id16 : id12;
        checkOutput($sformatf("gnt%0d", n), 32'(ogl), 32'(expGnt));
        if (expGnt) checkOutput($sformatf("id%0d", n), 32'(oid), 32'(expId));
        gotId = expGnt ? int'(oid) : -1;
        @(posedge clk);
        #1;
        if (!rn) begin
            mBusy[k] = '0; mPtr[k] = 0; mCnt[k] = 0; mErr[k] = 1'b0;
        end else begin
            fOk = fv && (fid < n) && mBusy[k][fid];
            if (expGnt) begin
                mBusy[k][expId] = 1'b1; mPtr[k] = expId; mCnt[k]++;
            end
            if (fv) begin
                if (fOk) begin
                    mBusy[k][fid] = 1'b0; mCnt[k]--;
                end else begin
                    mErr[k] = 1'b1;
                end
            end
        end
        if (k == 0) begin
            rstn16 = 1'b1; req16 = 1'b0; fv16 = 1'b0;
            checkOutput("busy16",  32'(busy16),  32'(mBusy[0]));
            checkOutput("cnt16",   32'(cnt16),   32'(mCnt[0]));
            checkOutput("full16",  32'(full16),  32'(mCnt[0] == 16));
            checkOutput("empty16", 32'(empty16), 32'(mCnt[0] == 0));
            checkOutput("err16",   32'(err16),   32'(mErr[0]));
        end else begin
            rstn12 = 1'b1; req12 = 1'b0; fv12 = 1'b0;
            checkOutput("busy12",  32'(busy12),  32'(mBusy[1]));
            checkOutput("cnt12",   32'(cnt12),   32'(mCnt[1]));
            checkOutput("full12",  32'(full12),  32'(mCnt[1] == 12));
            checkOutput("empty12", 32'(empty12), 32'(mCnt[1] == 0));
            checkOutput("err12",   32'(err12),   32'(mErr[1]));
        end
    endtask

    initial begin
        int got;
        int fid;
        bit rq, fv;
        for (int k = 0; k < 2; k++) begin
            mBusy[k] = '0; mPtr[k] = 0; mCnt[k] = 0; mErr[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset with a request pending must not grant.
        applyStimulus(0, 1, 0, 0, 0, got);
        applyStimulus(0, 1, 0, 0, 0, got);
        checkOutput("rst_empty16", 32'(empty16), 32'd1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1, got);
            checkOutput("first_ids", 32'(got), 32'(15 - i));
        end
        checkOutput("busy_e000", 32'(busy16), 32'h0000_E000);
        checkOutput("cnt_3", 32'(cnt16), 32'd3);

        for (int i = 3; i < 16; i++) begin
            applyStimulus(0, 1, 0, 0, 1, got);
            checkOutput("fill_ids", 32'(got), 32'(15 - i));
        end
        checkOutput("full_16", 32'(full16), 32'd1);
        applyStimulus(0, 1, 0, 0, 1, got);
        checkOutput("no_gnt_full", 32'(got), 32'hFFFF_FFFF);
        checkOutput("cnt_16", 32'(cnt16), 32'd16);

        applyStimulus(0, 0, 1, 5, 1, got);
        applyStimulus(0, 1, 0, 0, 1, got);
        checkOutput("realloc_5", 32'(got), 32'd5);
        applyStimulus(0, 0, 1, 14, 1, got);
        applyStimulus(0, 0, 1, 2, 1, got);
        applyStimulus(0, 1, 0, 0, 1, got);
        checkOutput("next_fit_2", 32'(got), 32'd2);
        applyStimulus(0, 1, 0, 0, 1, got);
        checkOutput("wrap_14", 32'(got), 32'd14);

        applyStimulus(0, 1, 1, 7, 1, got);
        checkOutput("same_cycle_nogrant", 32'(got), 32'hFFFF_FFFF);
        checkOutput("cnt_15", 32'(cnt16), 32'd15);
        applyStimulus(0, 1, 0, 0, 1, got);
        checkOutput("realloc_7", 32'(got), 32'd7);
        checkOutput("cnt_back_16", 32'(cnt16), 32'd16);

        applyStimulus(0, 0, 0, 0, 0, got);
        applyStimulus(0, 0, 1, 9, 1, got);
        checkOutput("err_set", 32'(err16), 32'd1);
        checkOutput("err_busy0", 32'(busy16), 32'd0);
        applyStimulus(0, 1, 0, 0, 1, got);
        applyStimulus(0, 1, 1, 15, 1, got);
        checkOutput("err_sticky", 32'(err16), 32'd1);

        applyStimulus(0, 0, 0, 0, 0, got);
        for (int i = 0; i < 300; i++) begin
            rq  = ($urandom_range(0, 3) != 0);
            fv  = ($urandom_range(0, 2) == 0);
            fid = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : pickBusy(0);
            applyStimulus(0, rq, fv, fid, ($urandom_range(0, 99) != 0), got);
        end

        applyStimulus(1, 0, 0, 0, 0, got);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 1, got);
            checkOutput("ids12", 32'(got), 32'(11 - i));
        end
        applyStimulus(1, 1, 1, 8, 0, got);
        checkOutput("midrst_busy", 32'(busy12), 32'd0);
        checkOutput("midrst_err", 32'(err12), 32'd0);
        applyStimulus(1, 1, 0, 0, 1, got);
        checkOutput("after_rst_11", 32'(got), 32'd11);
        applyStimulus(1, 0, 1, 13, 1, got);
        checkOutput("err_oob", 32'(err12), 32'd1);

        applyStimulus(1, 0, 0, 0, 0, got);
        for (int i = 0; i < 250; i++) begin
            rq  = ($urandom_range(0, 3) != 0);
            fv  = ($urandom_range(0, 2) == 0);
            fid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : pickBusy(1);
            applyStimulus(1, rq, fv, fid, ($urandom_range(0, 99) != 0), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/e_ring_alloc.md
Name: e_ring_alloc

Overview:
- Circular next-fit slot allocator for a table of N entries.
- Holds a registered busy vector and a one-hot rotating pointer.
- Grants at most one free entry per cycle; the search runs circularly from the last-allocated position.
- Accepts at most one release per cycle.
- Used by queue and tag managers to hand out entry IDs fairly, avoiding repeated reuse of low indices.

Parameters:
- N, 16, number of entries; N >= 2 and N % W == 0.
- W, 4, search segment width; 2..8. Sets segment granularity only, not function.
- IDW, $clog2(N), derived ID width; not overridable.
- CW, $clog2(N+1), derived count width; not overridable.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- alloc_req_i  in  1  allocation request
- alloc_gnt_o  out  1  grant; alloc_id_o is valid when high
- alloc_id_o  out  IDW  allocated entry ID
- free_vld_i  in  1  release request
- free_id_i  in  IDW  entry ID to release
- busy_o  out  N  registered busy vector
- cnt_o  out  CW  number of busy entries
- full_o  out  1  all entries busy (registered)
- empty_o  out  1  no entries busy (registered)
- err_o  out  1  sticky release error

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low on rst_n_i; all state updates on the rising edge.
- Reset values:
  - busy = 0, cnt_o = 0, full_o = 0, empty_o = 1, err_o = 0.
  - ptr = one-hot bit 0.
  - alloc_gnt_o = 0 while rst_n_i is low, regardless of alloc_req_i.
- Search order (combinational from registered busy and ptr):
  - Candidates are visited descending from index p-1 down to 0, then N-1 down to p, where p is the index of ptr.
  - The first entry with busy = 0 is selected; ptr's own entry is checked last.
  - Implemented as N/W chained W-wide segments. Each segment is a find-first-zero with carry-in/carry-out; the segment holding ptr generates the carry.
  - Wrap-around is resolved without combinational loops, e.g. by a masked pass and an unmasked pass.
- Grant:
  - alloc_gnt_o = alloc_req_i & ~full_o & rst_n_i. Zero-latency, same cycle as the request.
  - alloc_id_o = selected index while the grant is high. Its value is don't-care when the grant is low and must not be checked.
- On a grant edge: busy[alloc_id_o] <= 1; ptr <= onehot(alloc_id_o).
- Without a grant, ptr holds.
- Release:
  - When free_vld_i is high, free_id_i < N and busy[free_id_i] = 1: busy[free_id_i] <= 0 at the edge.
  - A freed entry becomes allocatable from the next cycle; the same-cycle search uses the pre-free busy vector.
- Release error:
  - Triggered when free_vld_i is high and either free_id_i >= N or busy[free_id_i] = 0.
  - Effect: err_o <= 1, busy unchanged, cnt unchanged.
  - err_o clears only on reset.
- Simultaneous grant and valid free:
  - IDs necessarily differ, since the granted entry is not busy.
  - Both take effect; cnt_o is unchanged.
- Count update:
  - cnt_o += 1 on a grant only; -= 1 on a valid free only.
  - cnt_o never exceeds N or drops below 0.
- Flags:
  - full_o = (cnt == N); empty_o = (cnt == 0). Both registered, consistent with busy_o.
- alloc_req_i while full: no grant, no state change, no error.
- Reset mid-operation: all entries released, ptr returns to bit 0, err_o cleared. Any in-flight free that cycle is discarded.

Test Plan:
- N=16, W=4; reset, then alloc_req_i held for 3 cycles -> grants 15, 14, 13 on consecutive cycles; cnt_o = 3; busy_o = 0xE000.
- Request for 16 cycles -> IDs 15..0 in order; full_o = 1; 17th cycle alloc_gnt_o = 0; cnt_o = 16; err_o = 0.
- From full: free 5, then allocate -> ID 5 and ptr = 5. Then free 14 and 2, then allocate twice -> IDs 2, then 14, exercising wrap past 0.
- From full: free_vld_i with ID 7 and alloc_req_i in the same cycle -> no grant that cycle; next cycle grant ID 7; cnt_o goes 16 -> 15 -> 16.
- Free ID 9 while idle-empty -> err_o = 1 next cycle, busy_o = 0, cnt_o = 0; err_o stays 1 after subsequent valid traffic until reset.
- N=12, W=3: allocate 4 (IDs 11..8), reset mid-stream with free_vld_i high -> busy_o = 0, err_o = 0; next alloc -> ID 11. Also free ID 13 -> err_o = 1.
